cim_weight_loader: RTL

- Host-side transmitter for the CIM array programming interface. It drives the D/WA/cima inputs that the array write controller consumes.
- It accepts a burst of 24-bit weight words over a valid/ready stream and buffers them in a small FIFO.
- It sequences them to consecutive word-line addresses from a base address, holds each write for a programmable number of cycles, then returns the array to compute mode.

---
 rtl/cim_ldr_pkg.sv | 25 ++
 rtl/cim_ldr_if.sv | 16 +
 rtl/cim_ldr_fifo.sv | 61 ++++++
 rtl/cim_weight_loader.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cim_ldr_pkg.sv
// Shared types and default sizes for the CIM weight loader.
package cim_ldr_pkg;

  localparam int unsigned DW_DEF         = 24;
  localparam int unsigned AW_DEF         = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned WR_CYC_DEF     = 2;

  // Hold counter only needs to reach WR_CYC-1.
  function automatic int unsigned hold_w(input int unsigned wr_cyc);
    return (wr_cyc > 1) ? $clog2(wr_cyc) : 1;
  endfunction

  localparam int unsigned HOLD_W_DEF = hold_w(WR_CYC_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_WRITE,
    ST_WAIT,
    ST_FLUSH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cim_ldr_if.sv
// Host weight stream plus the array programming bus (D/WA/wr_en/cima).
interface cim_ldr_if #(
  parameter int unsigned DW = cim_ldr_pkg::DW_DEF,
  parameter int unsigned AW = cim_ldr_pkg::AW_DEF
);
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [DW-1:0] D;
  logic [AW-1:0] WA;
  logic          wr_en;
  logic          cima;

  modport master (output s_valid, s_data, input s_ready, D, WA, wr_en, cima);
  modport slave  (input s_valid, s_data, output s_ready, D, WA, wr_en, cima);
endinterface

// File: rtl/cim_ldr_fifo.sv
// Small synchronous FIFO with clear; full/empty/count are registered.
module cim_ldr_fifo #(
  parameter int unsigned DW    = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;

  // A push on a full FIFO is legal when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    count_nxt = clear ? '0 : (count + CW'(do_push) - CW'(do_pop));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/cim_weight_loader.sv
// Streams buffered weight words to consecutive word-line addresses, holding each write WR_CYC cycles.
module cim_weight_loader
  import cim_ldr_pkg::*;
#(
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned WR_CYC     = WR_CYC_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  cim_ldr_if.slave      bus
);
  localparam int unsigned HW = hold_w(WR_CYC);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state, state_nxt;
  logic [AW-1:0] addr, addr_nxt, load_addr;
  logic [AW:0]   rem, rem_nxt;
  logic [AW:0]   acc_left, acc_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic [DW-1:0] d_nxt;
  logic [AW-1:0] wa_nxt;
  logic          wr_en_nxt, cima_nxt;
  logic          hs, avail, load;
  logic          fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
  logic [DW-1:0] fifo_head, head;
  logic [CW-1:0] fifo_cnt;

  cim_ldr_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (fifo_clear),
    .wdata (bus.s_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign bus.s_ready = busy && !fifo_full && (acc_left != '0);
  assign hs          = bus.s_valid && bus.s_ready;
  // A word arriving while the FIFO is empty bypasses it straight onto D.
  assign avail       = !fifo_empty || hs;
  assign head        = fifo_empty ? bus.s_data : fifo_head;

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    rem_nxt    = rem;
    acc_nxt    = acc_left - (AW+1)'(hs);
    hold_nxt   = hold;
    d_nxt      = bus.D;
    wa_nxt     = bus.WA;
    wr_en_nxt  = 1'b0;
    load       = 1'b0;
    load_addr  = addr;
    fifo_clear = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          if (count != '0) begin
            addr_nxt  = base_addr;
            rem_nxt   = count;
            acc_nxt   = count;
            state_nxt = ST_PREP;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_PREP: begin
        state_nxt = avail ? ST_WRITE : ST_WAIT;
        load      = avail;
      end
      ST_WRITE: begin
        if (hold != HW'(WR_CYC - 1)) begin
          wr_en_nxt = 1'b1;
          hold_nxt  = hold + HW'(1);
        end else begin
          addr_nxt = addr + AW'(1);
          rem_nxt  = rem - (AW+1)'(1);
          if (rem == (AW+1)'(1)) begin
            state_nxt = ST_FLUSH;
          end else if (avail) begin
            load      = 1'b1;
            load_addr = addr + AW'(1);
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (avail) begin
          load      = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_FLUSH: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    if (load) begin
      d_nxt     = head;
      wa_nxt    = load_addr;
      hold_nxt  = '0;
      wr_en_nxt = 1'b1;
    end

    // Abort overrides everything once a burst is underway.
    if (abort && (state != ST_IDLE) && (state != ST_DONE)) begin
      state_nxt  = ST_DONE;
      fifo_clear = 1'b1;
      wr_en_nxt  = 1'b0;
      load       = 1'b0;
      acc_nxt    = '0;
      rem_nxt    = '0;
    end

    fifo_pop  = load && !fifo_empty;
    fifo_push = hs && !(load && fifo_empty);
    cima_nxt  = (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      addr      <= '0;
      rem       <= '0;
      acc_left  <= '0;
      hold      <= '0;
      bus.D     <= '0;
      bus.WA    <= '0;
      bus.wr_en <= 1'b0;
      bus.cima  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      rem       <= rem_nxt;
      acc_left  <= acc_nxt;
      hold      <= hold_nxt;
      bus.D     <= d_nxt;
      bus.WA    <= wa_nxt;
      bus.wr_en <= wr_en_nxt;
      bus.cima  <= cima_nxt;
      busy      <= !cima_nxt;
      done      <= (state_nxt == ST_DONE);
    end
  end

  // Every accepted word has been written by the time recovery starts.
  always_ff @(posedge clk) begin
    if (rstn && (state == ST_FLUSH)) assert (fifo_cnt == '0);
  end

endmodule
